fifo_wr_arbiter: RTL and testbench

Shares the single write port of one `FIFO` instance among `NUM_REQ` packet-oriented requesters. Arbitration is round-robin, and a grant is locked for a whole packet. The block keeps a credit count of free FIFO entries, because the FIFO has no input-side ready. It sits directly in front of the FIFO: `OUT_fifoValid` and `OUT_fifoData` drive the FIFO's `IN_valid` and `IN_data`, and the FIFO's dequeue handshake is fed back on `IN_fifoDeq`.

---
 rtl/fifo_arb_pkg.sv | 14 +
 rtl/rr_picker.sv | 27 ++
 rtl/fifo_wr_arbiter.sv | 96 +++++++++
 tb/tb_fifo_wr_arbiter.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_arb_pkg.sv
// Shared types and helpers for the FIFO write-port arbiter.
package fifo_arb_pkg;

    typedef enum logic {
        ARB_IDLE   = 1'b0,
        ARB_LOCKED = 1'b1
    } ArbState_t;

    // Counter width able to hold 0..depth inclusive
    function automatic int credWidth(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin picker: first set request at or above start, with wrap.
module rr_picker #(
    parameter  int NUM_REQ = 4,
    localparam int IW      = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IW-1:0]      start,
    output logic               found,
    output logic [IW-1:0]      idx
);

    always_comb begin
        int cand;
        found = 1'b0;
        idx   = '0;
        cand  = 0;
        // Walk from the farthest candidate down so the closest to start wins last
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            cand = (int'(start) + i) % NUM_REQ;
            if (req[cand]) begin
                found = 1'b1;
                idx   = IW'(cand);
            end
        end
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Packet-locked round-robin arbiter sharing one FIFO write port, with credit-based
// flow control since the FIFO exposes no input-side ready.
module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter  int NUM_REQ = 4,
    parameter  int WIDTH   = 32,
    parameter  int DEPTH   = 128,
    localparam int IW      = $clog2(NUM_REQ),
    localparam int CW      = credWidth(DEPTH)
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [NUM_REQ-1:0]              IN_reqValid,
    input  logic [NUM_REQ-1:0][WIDTH-1:0]   IN_reqData,
    input  logic [NUM_REQ-1:0]              IN_reqLast,
    output logic [NUM_REQ-1:0]              OUT_reqReady,
    output logic                            OUT_fifoValid,
    output logic [WIDTH-1:0]                OUT_fifoData,
    input  logic                            IN_fifoDeq,
    output logic [IW-1:0]                   OUT_grantIdx,
    output logic [CW-1:0]                   OUT_credits
);

    ArbState_t      state;
    logic [IW-1:0]  rr_ptr;
    logic           pick_found;
    logic [IW-1:0]  pick_idx;
    logic           has_credit;
    logic           accept;
    logic           accept_last;
    logic [IW-1:0]  owner_inc;
    logic [CW-1:0]  credits_nxt;

    rr_picker #(.NUM_REQ(NUM_REQ)) u_picker (
        .req   (IN_reqValid),
        .start (rr_ptr),
        .found (pick_found),
        .idx   (pick_idx)
    );

    assign has_credit  = (OUT_credits != '0);
    assign accept      = (state == ARB_LOCKED) && has_credit && IN_reqValid[OUT_grantIdx];
    assign accept_last = accept && IN_reqLast[OUT_grantIdx];
    assign owner_inc   = (OUT_grantIdx == IW'(NUM_REQ - 1)) ? '0 : OUT_grantIdx + IW'(1);

    always_comb begin
        OUT_reqReady = '0;
        if (state == ARB_LOCKED && has_credit)
            OUT_reqReady[OUT_grantIdx] = 1'b1;
    end

    // Accept and dequeue in the same cycle cancel; a return at full count is dropped
    always_comb begin
        credits_nxt = OUT_credits;
        if (accept && !IN_fifoDeq)
            credits_nxt = OUT_credits - CW'(1);
        else if (!accept && IN_fifoDeq && OUT_credits != CW'(DEPTH))
            credits_nxt = OUT_credits + CW'(1);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= ARB_IDLE;
            rr_ptr        <= '0;
            OUT_grantIdx  <= '0;
            OUT_fifoValid <= 1'b0;
            OUT_fifoData  <= '0;
            OUT_credits   <= CW'(DEPTH);
        end else begin
            OUT_fifoValid <= accept;
            OUT_credits   <= credits_nxt;
            if (accept)
                OUT_fifoData <= IN_reqData[OUT_grantIdx];
            case (state)
                ARB_IDLE: begin
                    if (pick_found) begin
                        OUT_grantIdx <= pick_idx;
                        state        <= ARB_LOCKED;
                    end
                end
                ARB_LOCKED: begin
                    if (accept_last) begin
                        rr_ptr <= owner_inc;
                        state  <= ARB_IDLE;
                    end
                end
                default: state <= ARB_IDLE;
            endcase
        end
    end

    a_credit_overflow: assert property (@(posedge clk) disable iff (!rst)
        !(OUT_credits == CW'(DEPTH) && IN_fifoDeq));

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Bench for fifo_wr_arbiter: directed scenarios plus random traffic against a rule-level model.
module tb_fifo_wr_arbiter;

    localparam int N  = 4;
    localparam int W  = 32;
    localparam int D  = 128;
    localparam int D2 = 4;
    localparam int IW = $clog2(N);
    localparam int CW = $clog2(D + 1);
    localparam int CW2 = $clog2(D2 + 1);

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [N-1:0]        valid, last, ready;
    logic [N-1:0][W-1:0] data;
    logic                fv, deq;
    logic [W-1:0]        fd;
    logic [IW-1:0]       gidx;
    logic [CW-1:0]       cred;

    logic [N-1:0]        v2, l2, rdy2;
    logic [N-1:0][W-1:0] d2;
    logic                fv2, deq2;
    logic [W-1:0]        fd2;
    logic [IW-1:0]       gidx2;
    logic [CW2-1:0]      cr2;

    fifo_wr_arbiter #(.NUM_REQ(N), .WIDTH(W), .DEPTH(D)) dut (
        .clk(clk), .rst(rst),
        .IN_reqValid(valid), .IN_reqData(data), .IN_reqLast(last),
        .OUT_reqReady(ready), .OUT_fifoValid(fv), .OUT_fifoData(fd),
        .IN_fifoDeq(deq), .OUT_grantIdx(gidx), .OUT_credits(cred)
    );

    fifo_wr_arbiter #(.NUM_REQ(N), .WIDTH(W), .DEPTH(D2)) dut_small (
        .clk(clk), .rst(rst),
        .IN_reqValid(v2), .IN_reqData(d2), .IN_reqLast(l2),
        .OUT_reqReady(rdy2), .OUT_fifoValid(fv2), .OUT_fifoData(fd2),
        .IN_fifoDeq(deq2), .OUT_grantIdx(gidx2), .OUT_credits(cr2)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    // Reference model: packet owner, fairness pointer, free-entry count, pending write
    bit       m_locked, m_fv, m_acc;
    int       m_owner, m_rr, m_cred;
    logic [W-1:0] m_fd;

    logic [W-1:0] obs_data [$];
    int           obs_cyc  [$];
    int           obs_gnt  [$];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic model_reset();
        m_locked = 0; m_owner = 0; m_rr = 0; m_cred = D; m_fv = 0; m_fd = '0; m_acc = 0;
    endtask

    // Inputs are already applied; compare, advance the model, move to the next negedge
    task automatic step();
        logic [N-1:0] er;
        #1;
        er = '0;
        if (m_locked && m_cred > 0) er[m_owner] = 1'b1;
        chk("ready", ready, er);
        chk("fifo_valid", fv, m_fv);
        chk("fifo_data", fd, m_fd);
        chk("grant", gidx, m_owner);
        chk("credits", cred, m_cred);
        if (fv) begin
            obs_data.push_back(fd);
            obs_cyc.push_back(cyc);
            obs_gnt.push_back(int'(gidx));
        end
        if (!rst) begin
            model_reset();
        end else begin
            m_acc = m_locked && valid[m_owner] && m_cred > 0;
            m_fv  = m_acc;
            if (m_acc) m_fd = data[m_owner];
            if (!m_locked) begin
                for (int k = 0; k < N; k++) begin
                    if (valid[(m_rr + k) % N]) begin
                        m_owner  = (m_rr + k) % N;
                        m_locked = 1;
                        break;
                    end
                end
            end else if (m_acc && last[m_owner]) begin
                m_locked = 0;
                m_rr     = (m_owner + 1) % N;
            end
            m_cred = m_cred - int'(m_acc) + int'(deq);
        end
        @(negedge clk);
        cyc++;
    endtask

    task automatic clear_obs();
        obs_data.delete(); obs_cyc.delete(); obs_gnt.delete();
    endtask

    task automatic do_reset();
        valid = '0; last = '0; deq = 1'b0;
        rst = 1'b0;
        model_reset();
        step();
        step();
        rst = 1'b1;
        clear_obs();
    endtask

    task automatic send(input int r, input int nb, input logic [W-1:0] base, input int budget);
        int i, n;
        i = 0; n = 0;
        while (i < nb && n < budget) begin
            valid[r] = 1'b1;
            data[r]  = base + W'(i);
            last[r]  = (i == nb - 1);
            step();
            if (m_acc) i++;
            n++;
        end
        valid[r] = 1'b0;
        last[r]  = 1'b0;
        chk("send_done", i, nb);
    endtask

    initial begin
        int n, wcnt, acc_cnt, snap;
        rst = 1'b0; valid = '0; last = '0; data = '0; deq = 1'b0;
        v2 = '0; l2 = '0; d2 = '0; deq2 = 1'b0;
        model_reset();
        @(negedge clk);
        step();
        chk("rst_ready_small", rdy2, 0);
        chk("rst_credits_small", cr2, D2);
        rst = 1'b1;
        clear_obs();

        // Single 3-beat packet from requester 2
        send(2, 3, 32'hA, 20);
        step(); step();
        chk("single_writes", obs_data.size(), 3);
        if (obs_data.size() >= 3) begin
            chk("single_d0", obs_data[0], 32'hA);
            chk("single_d1", obs_data[1], 32'hB);
            chk("single_d2", obs_data[2], 32'hC);
            chk("single_consec", obs_cyc[2] - obs_cyc[0], 2);
        end
        chk("single_credits", cred, 125);
        chk("single_grant", gidx, 2);

        // Round-robin with every requester streaming single-beat packets
        do_reset();
        valid = '1; last = '1;
        for (int c = 0; c < 12; c++) begin
            for (int r = 0; r < N; r++) data[r] = $urandom;
            step();
        end
        valid = '0; last = '0;
        step(); step();
        chk("rr_writes", obs_gnt.size() >= 5, 1);
        if (obs_gnt.size() >= 5) begin
            for (int i = 0; i < 5; i++) chk("rr_order", obs_gnt[i], i % N);
            for (int i = 0; i < 4; i++) chk("rr_spacing", obs_cyc[i+1] - obs_cyc[i], 2);
        end

        // Accept and dequeue in the same cycle
        valid[1] = 1'b1; data[1] = 32'h55; last[1] = 1'b0;
        acc_cnt = 0; n = 0;
        while (acc_cnt < 3 && n < 20) begin
            last[1] = (acc_cnt == 2);
            deq = (m_cred < D);
            snap = m_cred;
            step();
            if (m_acc && deq) chk("acc_deq_credits", cred, snap);
            if (m_acc) acc_cnt++;
            n++;
        end
        chk("acc_deq_done", acc_cnt, 3);
        valid = '0; last = '0; deq = 1'b0;
        step(); step();

        // Packet lock: owner 0 stalls mid-packet while requester 1 waits
        do_reset();
        valid[1] = 1'b1; last[1] = 1'b1; data[1] = 32'h11;
        valid[0] = 1'b1; last[0] = 1'b0; data[0] = 32'h100;
        n = 0;
        do begin step(); n++; end while (!m_acc && n < 10);
        chk("lock_owner", gidx, 0);
        valid[0] = 1'b0;
        for (int c = 0; c < 4; c++) begin
            step();
            chk("lock_rdy1", ready[1], 0);
        end
        valid[0] = 1'b1; last[0] = 1'b1; data[0] = 32'h101;
        n = 0;
        do begin step(); n++; end while (!m_acc && n < 10);
        valid[0] = 1'b0; last[0] = 1'b0;
        step();
        chk("lock_next_grant", gidx, 1);
        chk("lock_rdy1_after", ready[1], 1);
        step();
        valid = '0; last = '0;
        step(); step();

        // Reset during beat 2 of a 4-beat packet, then requester 3 is served
        do_reset();
        valid[0] = 1'b1; last[0] = 1'b0; data[0] = 32'h200;
        n = 0;
        do begin step(); n++; end while (!m_acc && n < 10);
        data[0] = 32'h201;
        rst = 1'b0;
        #1;
        chk("mrst_valid", fv, 0);
        chk("mrst_data", fd, 0);
        chk("mrst_credits", cred, D);
        chk("mrst_grant", gidx, 0);
        chk("mrst_ready", ready, 0);
        model_reset();
        step();
        valid[0] = 1'b0;
        step();
        rst = 1'b1;
        clear_obs();
        send(3, 2, 32'h300, 20);
        step(); step();
        chk("mrst_new_grant", gidx, 3);
        chk("mrst_new_writes", obs_data.size(), 2);
        if (obs_data.size() >= 2) chk("mrst_new_data", obs_data[1], 32'h301);

        // Random traffic
        for (int c = 0; c < 1500; c++) begin
            for (int r = 0; r < N; r++) begin
                valid[r] = ($urandom_range(0, 9) < 6);
                last[r]  = ($urandom_range(0, 2) == 0);
                data[r]  = $urandom;
            end
            deq = (m_cred < D) && ($urandom_range(0, 2) == 0);
            step();
        end
        valid = '0; last = '0; deq = 1'b0;
        step();

        // Credit exhaustion on the 4-entry instance
        v2[1] = 1'b1; d2[1] = 32'h77; l2[1] = 1'b0;
        wcnt = 0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk); #1;
            if (fv2) wcnt++;
        end
        chk("exh_writes", wcnt, 4);
        chk("exh_credits", cr2, 0);
        chk("exh_ready", rdy2, 0);
        deq2 = 1'b1;
        @(negedge clk);
        deq2 = 1'b0;
        #1;
        chk("exh_deq_ready", rdy2, 4'b0010);
        @(negedge clk); #1;
        chk("exh_deq_write", fv2, 1);
        chk("exh_deq_credits", cr2, 0);
        wcnt = 0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk); #1;
            if (fv2) wcnt++;
        end
        chk("exh_no_more", wcnt, 0);
        v2 = '0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
